// File: rtl/fifobuf_pkg.sv
// fifobuf_pkg
//   Shared definitions for the fifobuf family:
//   - MODE_STD / MODE_FWFT : read-mode selectors for the FWFT parameter
//   - log2w()              : ceil(log2(n)) with a floor of 1, used to size
//                            pointers and the level counter
package fifobuf_pkg;

   localparam int MODE_STD  = 0;
   localparam int MODE_FWFT = 1;

   function automatic int log2w(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifobuf_dpram.sv
// fifobuf_dpram
//   Simple dual-port storage, DWIDTH x DEPTH, one write port and one read
//   port on the same clock. Both ports are synchronous: a read returns the
//   addressed word on rdata in the cycle after ren. No reset on contents.
// Ports:
//   clk   - clock, rising edge
//   wen   - write enable;  waddr / wdata - write address / data
//   ren   - read enable;   raddr        - read address
//   rdata - registered read data (holds while ren is low)
module fifobuf_dpram
   import fifobuf_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = log2w(DEPTH)
) (
   input  logic              clk,
   input  logic              wen,
   input  logic [AW-1:0]     waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              ren,
   input  logic [AW-1:0]     raddr,
   output logic [DWIDTH-1:0] rdata
);

   logic [DWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) mem[waddr] <= wdata;
      if (ren) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifobuf_param.sv
// fifobuf_param
//   Parameterised synchronous FIFO with standard or first-word-fall-through
//   read mode, registered status flags and sticky overflow/underflow flags.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   wren, idata     - write request / data; accepted when wren && iready
//   iready          - not full
//   rden            - read request; accepted when rden && oready
//   odata           - read data (standard: registered after a read;
//                     FWFT: current head word while oready)
//   oready          - data available
//   level           - stored word count (log2(DEPTH)+1 bits)
//   afull / aempty  - level >= AFULL_TH / level <= AEMPTY_TH
//   ovf / udf / err - sticky overflow, underflow, and their OR
//   errclr          - clears ovf and udf (a coincident new error wins)
module fifobuf_param
   import fifobuf_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int DEPTH     = 16,
   parameter int FWFT      = MODE_STD,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   localparam int AW       = log2w(DEPTH),
   localparam int LW       = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wren,
   input  logic [DWIDTH-1:0] idata,
   output logic              iready,
   input  logic              rden,
   output logic [DWIDTH-1:0] odata,
   output logic              oready,
   output logic [LW-1:0]     level,
   output logic              afull,
   output logic              aempty,
   output logic              ovf,
   output logic              udf,
   output logic              err,
   input  logic              errclr
);

   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

   logic [AW-1:0]     wptr, rptr, rptr_nxt;
   logic [LW-1:0]     level_nxt, level_after_rd;
   logic              we, re;
   logic              byp_load;
   logic              byp_sel_p1;
   logic [DWIDTH-1:0] byp_data_p1;
   logic [DWIDTH-1:0] ram_q_p1;
   logic              odv_p1;
   logic              ram_ren;
   logic [AW-1:0]     ram_raddr;

   // Acceptance uses the registered flags, so a full FIFO rejects a write
   // even when a read is accepted in the same cycle (and vice versa).
   assign we = wren & iready & ~reset;
   assign re = rden & oready & ~reset;

   assign rptr_nxt       = rptr + AW'(re);
   assign level_after_rd = level - LW'(re);

   // A write lands directly at the head when nothing else would remain
   // after this cycle's read; the RAM cannot deliver it in time, so the
   // word is captured in a bypass register instead.
   assign byp_load = we & (level_after_rd == '0);

   always_comb begin
      level_nxt = level;
      if (we && !re)      level_nxt = level + LW'(1);
      else if (re && !we) level_nxt = level - LW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         iready     <= 1'b1;
         oready     <= 1'b0;
         afull      <= ('0 >= AFULL_L);
         aempty     <= 1'b1;
         ovf        <= 1'b0;
         udf        <= 1'b0;
         odv_p1     <= 1'b0;
         byp_sel_p1 <= 1'b0;
      end else begin
         if (we) wptr <= wptr + AW'(1);
         rptr       <= rptr_nxt;
         level      <= level_nxt;
         iready     <= (level_nxt != DEPTH_L);
         oready     <= (level_nxt != '0);
         afull      <= (level_nxt >= AFULL_L);
         aempty     <= (level_nxt <= AEMPTY_L);
         ovf        <= (ovf & ~errclr) | (wren & ~iready);
         udf        <= (udf & ~errclr) | (rden & ~oready);
         if (re) odv_p1 <= 1'b1;
         byp_sel_p1 <= byp_load;
      end
   end

   always_ff @(posedge clk) begin
      if (byp_load) byp_data_p1 <= idata;
   end

   // FWFT keeps the RAM output tracking the head the FIFO will have next
   // cycle; standard mode reads the head only on an accepted read so the
   // RAM output register holds odata between reads.
   assign ram_ren   = (FWFT == MODE_FWFT) ? 1'b1 : re;
   assign ram_raddr = (FWFT == MODE_FWFT) ? rptr_nxt : rptr;

   fifobuf_dpram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .wen   (we),
      .waddr (wptr),
      .wdata (idata),
      .ren   (ram_ren),
      .raddr (ram_raddr),
      .rdata (ram_q_p1)
   );

   // ---- stage p1: output select ----
   // odv_p1 masks the unreset RAM register until a post-reset read has
   // loaded it, so no stale word is ever visible.
   always_comb begin
      odata = '0;
      if (FWFT == MODE_FWFT) begin
         if (oready) odata = byp_sel_p1 ? byp_data_p1 : ram_q_p1;
      end else begin
         if (odv_p1) odata = ram_q_p1;
      end
   end

   assign err = ovf | udf;

endmodule

// File: tb/tb_fifobuf_param.sv
module tb_fifobuf_param;

   localparam int DW = 8;
   localparam int DP = 16;
   localparam int AF = 14;
   localparam int AE = 2;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wren = 1'b0;
   logic [DW-1:0] idata = '0;
   logic          rden = 1'b0;
   logic          errclr = 1'b0;

   logic          s_iready, s_oready, s_afull, s_aempty, s_ovf, s_udf, s_err;
   logic [DW-1:0] s_odata;
   logic [LW-1:0] s_level;
   logic          f_iready, f_oready, f_afull, f_aempty, f_ovf, f_udf, f_err;
   logic [DW-1:0] f_odata;
   logic [LW-1:0] f_level;

   int n_chk = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   fifobuf_param #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_std (
      .clk(clk), .reset(reset), .wren(wren), .idata(idata), .iready(s_iready),
      .rden(rden), .odata(s_odata), .oready(s_oready), .level(s_level),
      .afull(s_afull), .aempty(s_aempty), .ovf(s_ovf), .udf(s_udf), .err(s_err),
      .errclr(errclr));

   fifobuf_param #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_fwft (
      .clk(clk), .reset(reset), .wren(wren), .idata(idata), .iready(f_iready),
      .rden(rden), .odata(f_odata), .oready(f_oready), .level(f_level),
      .afull(f_afull), .aempty(f_aempty), .ovf(f_ovf), .udf(f_udf), .err(f_err),
      .errclr(errclr));

   // Behavioural model: a word queue plus sticky flags. Both DUTs see the
   // same stimulus, so one queue serves both; only odata differs by mode.
   logic [DW-1:0] q[$];
   bit            m_ovf, m_udf;
   logic [DW-1:0] m_std_odata;
   bit            m_full, m_empty;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_std_odata = '0;
      end else begin
         m_full  = (q.size() == DP);
         m_empty = (q.size() == 0);
         m_ovf = (m_ovf && !errclr) || (wren && m_full);
         m_udf = (m_udf && !errclr) || (rden && m_empty);
         if (rden && !m_empty) m_std_odata = q.pop_front();
         if (wren && !m_full)  q.push_back(idata);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      if (check_en) begin
         int sz;
         logic [DW-1:0] head;
         sz = q.size();
         head = (sz != 0) ? q[0] : '0;
         chk("std.level",  32'(s_level),  32'(sz));
         chk("std.iready", 32'(s_iready), 32'(sz != DP));
         chk("std.oready", 32'(s_oready), 32'(sz != 0));
         chk("std.afull",  32'(s_afull),  32'(sz >= AF));
         chk("std.aempty", 32'(s_aempty), 32'(sz <= AE));
         chk("std.ovf",    32'(s_ovf),    32'(m_ovf));
         chk("std.udf",    32'(s_udf),    32'(m_udf));
         chk("std.err",    32'(s_err),    32'(m_ovf | m_udf));
         chk("std.odata",  32'(s_odata),  32'(m_std_odata));
         chk("fwft.level",  32'(f_level),  32'(sz));
         chk("fwft.iready", 32'(f_iready), 32'(sz != DP));
         chk("fwft.oready", 32'(f_oready), 32'(sz != 0));
         chk("fwft.afull",  32'(f_afull),  32'(sz >= AF));
         chk("fwft.aempty", 32'(f_aempty), 32'(sz <= AE));
         chk("fwft.ovf",    32'(f_ovf),    32'(m_ovf));
         chk("fwft.udf",    32'(f_udf),    32'(m_udf));
         chk("fwft.err",    32'(f_err),    32'(m_ovf | m_udf));
         if (sz != 0) chk("fwft.odata", 32'(f_odata), 32'(head));
      end
   end

   // Drive one cycle of inputs from a negedge; return at the next negedge.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit c, input bit rs = 1'b0);
      wren = w; idata = d; rden = r; errclr = c; reset = rs;
      @(negedge clk);
      wren = 1'b0; rden = 1'b0; errclr = 1'b0; reset = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] exp_w;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_en = 1'b1;

      // Reset state, literal
      chk("rst.level",  32'(s_level), 0);
      chk("rst.iready", 32'(s_iready), 1);
      chk("rst.oready", 32'(f_oready), 0);
      chk("rst.aempty", 32'(s_aempty), 1);
      chk("rst.afull",  32'(f_afull), 0);
      chk("rst.odata",  32'(s_odata), 0);
      chk("rst.odataf", 32'(f_odata), 0);
      chk("rst.err",    32'(f_err), 0);

      // Fill 0x01..0x10, then drain in order
      for (int i = 1; i <= DP; i++) begin
         step(1'b1, DW'(i), 1'b0, 1'b0);
         chk("fill.afull", 32'(s_afull), 32'(i >= 14));
      end
      chk("fill.iready", 32'(s_iready), 0);
      chk("fill.level",  32'(f_level), 16);
      for (int i = 1; i <= DP; i++) begin
         chk("drain.fwft", 32'(f_odata), 32'(i));
         step(1'b0, '0, 1'b1, 1'b0);
         chk("drain.std", 32'(s_odata), 32'(i));
      end
      chk("drain.oready", 32'(s_oready), 0);
      chk("drain.aempty", 32'(f_aempty), 1);
      chk("drain.err",    32'(s_err), 0);

      // Overflow on full, then errclr
      for (int i = 0; i < DP; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf.flag",  32'(s_ovf), 1);
      chk("ovf.err",   32'(f_err), 1);
      chk("ovf.level", 32'(s_level), 16);
      chk("ovf.head",  32'(f_odata), 32'h40);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("ovf.clr", 32'(s_ovf), 0);
      for (int i = 0; i < DP; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("ovf.last", 32'(s_odata), 32'h4F);

      // Underflow with simultaneous write into empty
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      chk("udf.flag",  32'(s_udf), 1);
      chk("udf.level", 32'(f_level), 1);
      chk("udf.fwft",  32'(f_odata), 32'hA5);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("udf.std", 32'(s_odata), 32'hA5);
      chk("udf.clr", 32'(f_udf), 0);

      // Latency: FWFT write-to-visible, standard read-to-data
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("lat.fwft_rdy", 32'(f_oready), 1);
      chk("lat.fwft",     32'(f_odata), 32'h3C);
      chk("lat.std_hold", 32'(s_odata), 32'hA5);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("lat.std", 32'(s_odata), 32'h3C);

      // Steady-state streaming at level 8 with pointer wrap
      for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         step(1'b1, DW'(8'h90 + k), 1'b1, 1'b0);
         exp_w = (k < 8) ? DW'(8'h80 + k) : DW'(8'h90 + k - 8);
         chk("stream.level", 32'(s_level), 8);
         chk("stream.std",   32'(s_odata), 32'(exp_w));
      end
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

      // Reset mid-operation
      step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
      chk("mrst.level",  32'(s_level), 0);
      chk("mrst.oready", 32'(f_oready), 0);
      chk("mrst.iready", 32'(s_iready), 1);
      chk("mrst.err",    32'(f_err), 0);
      chk("mrst.odata",  32'(s_odata), 0);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("mrst.fwft", 32'(f_odata), 32'h77);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("mrst.std",   32'(s_odata), 32'h77);
      chk("mrst.empty", 32'(s_oready), 0);

      // Randomized phases: write-heavy, read-heavy, balanced
      for (int ph = 0; ph < 6; ph++) begin
         int pw, pr;
         pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
         pr = 100 - pw;
         for (int n = 0; n < 500; n++) begin
            step($urandom_range(99) < pw, DW'($urandom), $urandom_range(99) < pr,
                 $urandom_range(99) < 3, $urandom_range(999) < 4);
         end
      end

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
